spi_adc_responder: RTL

// - SPI responder that emulates the 8-channel 12-bit serial ADC read by the scope's SPI master.
// - Provides a bit-accurate ADC stand-in in the same FPGA for bring-up and loopback.
// - Oversamples the cs, sclk and din inputs on the system clock and decodes the 3-bit channel address.
// - Shifts the selected channel's 12-bit sample out on dout, MSB first.

---
 rtl/spi_adc_responder_if.sv | 27 ++
 rtl/spi_adc_responder.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/spi_adc_responder_if.sv
// Pin-level bundle between the scope's SPI master and the ADC stand-in,
// including the channel sample bus and the frame status pulses.
interface spi_adc_responder_if #(
  parameter int DATA_W = 12,
  parameter int ADDR_W = 3,
  parameter int NUM_CH = 8
);
  logic                     cs;
  logic                     sclk;
  logic                     din;
  logic [NUM_CH*DATA_W-1:0] ch_data;
  logic                     dout;
  logic                     dout_en;
  logic [ADDR_W-1:0]        ch_sel;
  logic                     frame_done;
  logic                     frame_err;

  modport master (
    output cs, sclk, din, ch_data,
    input  dout, dout_en, ch_sel, frame_done, frame_err
  );

  modport slave (
    input  cs, sclk, din, ch_data,
    output dout, dout_en, ch_sel, frame_done, frame_err
  );
endinterface

// File: rtl/spi_adc_responder.sv
// Emulates an 8-channel 12-bit serial ADC: oversampled SPI pins, address in frame N picks data for N+1.
// Pin edges are acted on SYNC_STAGES+1 clk cycles after they occur; no backpressure, sclk must be <= clk/8.
module spi_adc_responder #(
  parameter int DATA_W      = 12,
  parameter int ADDR_W      = 3,
  parameter int NUM_CH      = 8,
  parameter int FRAME_BITS  = 16,
  parameter int SYNC_STAGES = 2
) (
  input logic              clk,
  input logic              rst_n,
  spi_adc_responder_if.slave bus
);
  localparam int CNT_W = $clog2(FRAME_BITS + 1);
  localparam logic [CNT_W-1:0] LAST_RISE  = CNT_W'(FRAME_BITS);
  localparam logic [CNT_W-1:0] ADDR_FIRST = CNT_W'(3);
  localparam logic [CNT_W-1:0] ADDR_LAST  = CNT_W'(3 + ADDR_W - 1);
  localparam logic [CNT_W-1:0] LEAD_ZEROS = CNT_W'(FRAME_BITS - DATA_W - 1);

  typedef enum logic [1:0] {IDLE, ACTIVE, TAIL} state_t;

  state_t                   state;
  logic [SYNC_STAGES-1:0]   cs_sync, sclk_sync, din_sync, flush;
  logic                     cs_prev, sclk_prev, armed;
  logic                     cs_s, sclk_s, din_s;
  logic                     cs_fall, cs_rise, sclk_rise, sclk_fall;
  logic [CNT_W-1:0]         rise_cnt, fall_cnt, rise_next, fall_next;
  logic [DATA_W-1:0]        shift_reg;
  logic [ADDR_W-1:0]        addr_tmp, ch_sel;
  logic [NUM_CH*DATA_W-1:0] ch_flat;
  logic                     dout, dout_en, frame_done, frame_err;

  // cs/sclk synchronisers idle high so a reset never fakes an edge on them
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cs_sync   <= '1;
      sclk_sync <= '1;
      din_sync  <= '0;
      flush     <= '0;
      cs_prev   <= 1'b1;
      sclk_prev <= 1'b1;
    end else begin
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], bus.cs};
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], bus.sclk};
      din_sync  <= {din_sync[SYNC_STAGES-2:0], bus.din};
      flush     <= {flush[SYNC_STAGES-2:0], 1'b1};
      cs_prev   <= cs_s;
      sclk_prev <= sclk_s;
    end
  end

  assign cs_s      = cs_sync[SYNC_STAGES-1];
  assign sclk_s    = sclk_sync[SYNC_STAGES-1];
  assign din_s     = din_sync[SYNC_STAGES-1];
  assign cs_fall   = cs_prev & ~cs_s;
  assign cs_rise   = ~cs_prev & cs_s;
  assign sclk_rise = ~sclk_prev & sclk_s;
  assign sclk_fall = sclk_prev & ~sclk_s;
  assign rise_next = rise_cnt + 1'b1;
  assign fall_next = fall_cnt + 1'b1;
  assign ch_flat   = bus.ch_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      armed      <= 1'b0;
      dout       <= 1'b0;
      dout_en    <= 1'b0;
      ch_sel     <= '0;
      frame_done <= 1'b0;
      frame_err  <= 1'b0;
      shift_reg  <= '0;
      addr_tmp   <= '0;
      rise_cnt   <= '0;
      fall_cnt   <= '0;
    end else begin
      frame_done <= 1'b0;
      frame_err  <= 1'b0;
      // A frame already low when reset lifts is skipped: wait for real cs high first
      if (flush[SYNC_STAGES-1] && cs_s)
        armed <= 1'b1;

      case (state)
        IDLE: begin
          dout    <= 1'b0;
          dout_en <= 1'b0;
          if (armed && cs_fall) begin
            shift_reg <= ch_flat[int'(ch_sel)*DATA_W +: DATA_W];
            dout_en   <= 1'b1;
            rise_cnt  <= '0;
            fall_cnt  <= '0;
            state     <= ACTIVE;
          end
        end

        ACTIVE: begin
          if (sclk_rise && rise_next == LAST_RISE) begin
            rise_cnt   <= rise_next;
            ch_sel     <= addr_tmp;
            frame_done <= 1'b1;
            if (cs_rise) begin
              dout    <= 1'b0;
              dout_en <= 1'b0;
              state   <= IDLE;
            end else begin
              state <= TAIL;
            end
          end else if (cs_rise) begin
            frame_err <= 1'b1;
            dout      <= 1'b0;
            dout_en   <= 1'b0;
            state     <= IDLE;
          end else if (sclk_rise) begin
            rise_cnt <= rise_next;
            if (rise_next >= ADDR_FIRST && rise_next <= ADDR_LAST)
              addr_tmp <= {addr_tmp[ADDR_W-2:0], din_s};
          end else if (sclk_fall && rise_cnt != '0) begin
            // the idle-high lead-in fall before rise 1 is not a data edge
            fall_cnt <= fall_next;
            if (fall_next <= LEAD_ZEROS) begin
              dout <= 1'b0;
            end else begin
              dout      <= shift_reg[DATA_W-1];
              shift_reg <= {shift_reg[DATA_W-2:0], 1'b0};
            end
          end
        end

        TAIL: begin
          dout <= 1'b0;
          if (cs_s) begin
            dout_en <= 1'b0;
            state   <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

  assign bus.dout       = dout;
  assign bus.dout_en    = dout_en;
  assign bus.ch_sel     = ch_sel;
  assign bus.frame_done = frame_done;
  assign bus.frame_err  = frame_err;
endmodule
